// File: rtl/width_conv_pkg.sv
// Shared definitions for the upsizer/downsizer width-conversion pair:
// datapath widths, word/beat types and the downsizer state encoding.
package width_conv_pkg;

  localparam int WIDE_W   = 1024;
  localparam int NARROW_W = 256;

  typedef logic [WIDE_W-1:0]   wide_t;
  typedef logic [NARROW_W-1:0] narrow_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/downsizer.sv
// Serialises each wide input word into RATIO narrow beats, least-significant
// slice first, with back-to-back word acceptance on the last-beat handshake.
//
// Handshake: on either side a transfer happens on a rising edge where
// valid && ready. out_valid/out_data/out_last depend only on registered state;
// in_ready additionally depends combinationally on out_ready (last-beat path).
module downsizer
  import width_conv_pkg::*;
#(
  parameter int IN_W  = WIDE_W,
  parameter int OUT_W = NARROW_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] words_done,
  output logic             dbg_state
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  generate
    if ((IN_W % OUT_W) != 0 || RATIO < 1) begin : g_bad_ratio
      $error("downsizer: IN_W must be a positive integer multiple of OUT_W");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [IN_W-1:0]  data_q, data_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] words_done_q, words_done_d;

  logic beat_hs;
  logic last_hs;

  assign out_valid  = (state_q == SEND);
  assign busy       = (state_q == SEND);
  assign out_last   = (state_q == SEND) && (cnt_q == LAST_IDX);
  assign out_data   = data_q[cnt_q*OUT_W +: OUT_W];
  assign words_done = words_done_q;
  assign dbg_state  = state_q;

  assign beat_hs  = out_valid && out_ready;
  assign last_hs  = beat_hs && out_last;
  assign in_ready = (state_q == IDLE) || last_hs;

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    words_done_d = words_done_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (beat_hs) begin
          if (cnt_q != LAST_IDX) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            // Counter sticks at all-ones rather than wrapping.
            if (words_done_q != '1) begin
              words_done_d = words_done_q + 1'b1;
            end
            if (in_valid) begin
              data_d  = in_data;
              cnt_d   = '0;
              state_d = SEND;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      data_q       <= '0;
      cnt_q        <= '0;
      words_done_q <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      words_done_q <= words_done_d;
    end
  end

endmodule

// File: tb/tb_downsizer.sv
// Scoreboard bench for downsizer: beats are predicted when a word is accepted
// and compared as they leave; a CNT_W=2 twin checks counter saturation.
module tb_downsizer;

  localparam int IN_W  = 1024;
  localparam int OUT_W = 256;
  localparam int RATIO = IN_W / OUT_W;

  logic             clk;
  logic             rst;
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;
  logic [15:0]      words_done;
  logic             dbg_state;

  logic             s_in_ready;
  logic [OUT_W-1:0] s_out_data;
  logic             s_out_valid;
  logic             s_out_last;
  logic             s_busy;
  logic [1:0]       s_words_done;
  logic             s_dbg_state;

  int tests_run;
  int tests_failed;
  int cyc;
  int accept_cyc;

  logic [OUT_W:0] exp_q[$];
  int             beat_cyc[$];

  downsizer #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy),
    .words_done(words_done), .dbg_state(dbg_state)
  );

  downsizer #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(s_in_ready), .out_data(s_out_data), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_last(s_out_last), .busy(s_busy),
    .words_done(s_words_done), .dbg_state(s_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [OUT_W-1:0] got,
                       input logic [OUT_W-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [IN_W-1:0] w);
    logic done;
    done = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        accept_cyc = cyc;
        for (int b = 0; b < RATIO; b++)
          exp_q.push_back({(b == RATIO - 1), w[b*OUT_W +: OUT_W]});
      end
    end
    if (!done) check("accept_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    check("drain_timeout", exp_q.size(), 0);
    tick();
  endtask

  function automatic logic [IN_W-1:0] rand_word();
    logic [IN_W-1:0] w;
    for (int i = 0; i < IN_W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // scoreboard / monitor
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        check("in_ready_on_beat", in_ready, out_ready && exp_q[0][OUT_W]);
        if (out_ready) begin
          logic [OUT_W:0] e;
          e = exp_q.pop_front();
          beat_cyc.push_back(cyc);
          check("beat_data", out_data, e[OUT_W-1:0]);
          check("beat_last", out_last, e[OUT_W]);
        end else begin
          check("stall_data", out_data, exp_q[0][OUT_W-1:0]);
          check("stall_last", out_last, exp_q[0][OUT_W]);
        end
      end
    end
  end

  initial begin
    logic [IN_W-1:0] w;
    logic [6:0] pattern;
    tests_run = 0;
    tests_failed = 0;
    cyc = 0;
    accept_cyc = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;

    // reset held for two cycles
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_words_done", words_done, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    rst = 1'b0;
    tick();
    check("idle_out_valid", out_valid, 0);
    check("idle_in_ready", in_ready, 1);
    check("idle_state", dbg_state, 0);

    // single word, A..D
    out_ready = 1'b1;
    beat_cyc.delete();
    w = {{64{4'hD}}, {64{4'hC}}, {64{4'hB}}, {64{4'hA}}};
    send_word(w);
    wait_drain();
    check("single_beats", beat_cyc.size(), 4);
    if (beat_cyc.size() == 4) begin
      check("single_latency", beat_cyc[0] - accept_cyc, 1);
      check("single_span", beat_cyc[3] - beat_cyc[0], 3);
    end
    check("single_words_done", words_done, 1);
    check("single_idle", out_valid, 0);

    // backpressure 1,0,0,1,1,0,1
    out_ready = 1'b0;
    beat_cyc.delete();
    pattern = 7'b1011001;
    send_word(rand_word());
    for (int i = 0; i < 7; i++) begin
      out_ready = pattern[i];
      tick();
    end
    out_ready = 1'b1;
    check("bp_drained", exp_q.size(), 0);
    check("bp_beats", beat_cyc.size(), 4);
    if (beat_cyc.size() == 4) check("bp_span", beat_cyc[3] - beat_cyc[0], 6);
    wait_drain();
    check("bp_words_done", words_done, 2);
    check("bp_sat_words_done", s_words_done, 2);

    // back-to-back, three words
    beat_cyc.delete();
    for (int k = 0; k < 3; k++) send_word(rand_word());
    wait_drain();
    check("b2b_beats", beat_cyc.size(), 12);
    if (beat_cyc.size() == 12) check("b2b_span", beat_cyc[11] - beat_cyc[0], 11);
    check("b2b_words_done", words_done, 5);
    check("sat_words_done", s_words_done, 3);

    // reset after beat 1 of a word
    send_word(rand_word());
    tick();
    rst = 1'b1;
    out_ready = 1'b0;
    exp_q.delete();
    tick();
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_words_done", words_done, 0);
    check("midrst_out_data", out_data, 0);
    tick();
    check("midrst_no_beat", out_valid, 0);
    out_ready = 1'b1;
    beat_cyc.delete();
    send_word(rand_word());
    wait_drain();
    check("post_rst_beats", beat_cyc.size(), 4);
    check("post_rst_words_done", words_done, 1);
    check("post_rst_sat", s_words_done, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cyc=%0d expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
